// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset PC, NOP encoding and the fetch queue entry type.
package cpu_pkg;

  localparam logic [31:0] CPU_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] CPU_NOP      = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue holding {pc, instr} pairs with flush support.
// Define FETCH_QUEUE_BYPASS_EN to forward a push straight to the head while empty.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_valid,
  input  logic [31:0]                push_pc,
  input  logic [31:0]                push_instr,
  output logic                       full,
  input  logic                       pop_ready,
  output logic                       pop_valid,
  output logic [31:0]                pop_pc,
  output logic [31:0]                pop_instr,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  last_entry;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          empty;
  logic          bypass;
  logic          bypass_take;
  logic          push_store;
  logic          pop_mem;
  logic          pop_fire;

  assign push_entry = '{pc: push_pc, instr: push_instr};
  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign count      = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && push_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign pop_valid = !empty || bypass;

  // While empty the head shows the last entry handed to decode.
  always_comb begin
    head = last_entry;
    if (bypass)
      head = push_entry;
    else if (!empty)
      head = mem[rd_ptr];
  end

  assign pop_pc    = head.pc;
  assign pop_instr = head.instr;

  assign pop_fire    = pop_valid && pop_ready && !flush;
  assign bypass_take = bypass && pop_ready;
  assign pop_mem     = !empty && pop_ready && !flush;
  assign push_store  = push_valid && !full && !flush && !bypass_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      last_entry <= '{pc: RESET_PC, instr: CPU_NOP};
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_store)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_mem)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_store && !pop_mem)
        count_q <= count_q + 1'b1;
      else if (pop_mem && !push_store)
        count_q <= count_q - 1'b1;
      if (pop_fire)
        last_entry <= head;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_store)
      mem[wr_ptr] <= push_entry;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based scoreboard of expected pops.
module tb_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid;
  logic [31:0] push_pc;
  logic [31:0] push_instr;
  logic        full;
  logic        pop_ready;
  logic        pop_valid;
  logic [31:0] pop_pc;
  logic [31:0] pop_instr;
  logic        flush;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_pc;
  logic [31:0] last_instr;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_pc(push_pc), .push_instr(push_instr),
    .full(full), .pop_ready(pop_ready), .pop_valid(pop_valid),
    .pop_pc(pop_pc), .pop_instr(pop_instr), .flush(flush), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Registered-state checks, taken while push/flush are idle.
  task automatic idle_check();
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
    chk("pop_valid", 32'(pop_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() == 0) begin
      chk("hold_pc", pop_pc, last_pc);
      chk("hold_instr", pop_instr, last_instr);
    end
  endtask

  task automatic cycle(input bit pv, input logic [31:0] pc, input logic [31:0] ins,
                       input bit pr, input bit fl);
    bit byp;
    bit was_full;
    logic [63:0] e;
    idle_check();
    push_valid = pv; push_pc = pc; push_instr = ins; pop_ready = pr; flush = fl;
    #1;
    byp      = BYP && pv && !fl && (exp_q.size() == 0);
    was_full = (exp_q.size() == DEPTH);
    chk("pop_valid_live", 32'(pop_valid), 32'((exp_q.size() != 0) || byp));
    if (fl) begin
      exp_q.delete();
    end else if (pr && byp) begin
      chk("bypass_pc", pop_pc, pc);
      chk("bypass_instr", pop_instr, ins);
      last_pc = pc; last_instr = ins;
    end else begin
      if (pr && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pop_pc", pop_pc, e[63:32]);
        chk("pop_instr", pop_instr, e[31:0]);
        last_pc = e[63:32]; last_instr = e[31:0];
      end
      if (pv && !was_full)
        exp_q.push_back({pc, ins});
    end
    @(posedge clk);
    @(negedge clk);
    push_valid = 1'b0; pop_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; push_valid = 1'b0; push_pc = '0; push_instr = '0;
    pop_ready = 1'b0; flush = 1'b0;
    last_pc = 32'h0040_0000; last_instr = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_check();

    // Fill past capacity, then drain in order
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'h0040_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
    repeat (4) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    idle_check();

    // Steady push+pop at count 2 wraps the pointers
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 32'h0040_0100 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
    for (int i = 2; i < 12; i++)
      cycle(1'b1, 32'h0040_0100 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with a same-cycle push at count 3
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h0040_0200 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h0040_0FFC, 32'hDEAD_BEEF, 1'b1, 1'b1);
    cycle(1'b1, 32'h0040_0300, 32'hC100_0000, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Push into empty queue with pop_ready high
    cycle(1'b1, 32'h0040_0020, 32'h0000_0013, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Full queue: push with simultaneous pop is still dropped
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h0040_0400 + 32'(4 * i), 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h0040_0500, 32'hE100_0000, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle on a full queue
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h0040_0600 + 32'(4 * i), 32'hF000_0000 + 32'(i), 1'b0, 1'b0);
    idle_check();
    #2 rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_pop_pc", pop_pc, 32'h0040_0000);
    chk("rst_pop_instr", pop_instr, 32'h0);
    exp_q.delete();
    last_pc = 32'h0040_0000; last_instr = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    idle_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
